// File: rtl/red_stats_accumulator_if.sv
// Sample/statistics bus for red_stats_accumulator: pair handshake in, RED and window stats out.
interface red_stats_accumulator_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 24,
  parameter int unsigned CW   = 11
);
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] approx;
  logic [XLEN-1:0] exact;
  logic [RW-1:0]   red_out;
  logic            red_valid;
  logic [RW-1:0]   mred;
  logic [RW-1:0]   red_max;
  logic            stats_valid;
  logic [CW-1:0]   zero_div_cnt;

  modport master (
    output clear, in_valid, approx, exact,
    input  in_ready, red_out, red_valid, mred, red_max, stats_valid, zero_div_cnt
  );

  modport slave (
    input  clear, in_valid, approx, exact,
    output in_ready, red_out, red_valid, mred, red_max, stats_valid, zero_div_cnt
  );
endinterface

// File: rtl/red_stats_accumulator.sv
// Relative-error-distance statistics engine: per-pair RED via restoring divider,
// windowed mean (MRED) over 2^LOG2_N samples. Define RED_MAX_TRACK_EN to build
// the peak-RED tracker; otherwise red_max is tied to 0.
module red_stats_accumulator #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned LOG2_N = 10
) (
  input  logic clk,
  input  logic reset,
  red_stats_accumulator_if.slave bus
);
  localparam int unsigned IB  = 8;
  localparam int unsigned RW  = FRAC + IB;
  localparam int unsigned SW  = RW + LOG2_N;
  localparam int unsigned CW  = LOG2_N + 1;
  localparam int unsigned EW  = XLEN + 1;
  localparam int unsigned NW  = EW + FRAC;
  localparam int unsigned RMW = XLEN + 2;
  localparam int unsigned IW  = $clog2(RW);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, ACC, DONE} state_t;

  state_t state, state_next;

  logic [XLEN-1:0] a_q, e_q;
  logic [EW-1:0]   diff, ed, d;
  logic            sat, d_zero;
  logic [NW-1:0]   num;
  logic [RMW-1:0]  rem, rem_sh, rem_nx;
  logic [RW-1:0]   low, quo, quo_nx;
  logic            ge;
  logic [IW-1:0]   iter;
  logic [RW-1:0]   red_q, mred_q;
  logic            red_valid_q, stats_q;
  logic [SW-1:0]   sum_q, sum_nx;
  logic [CW-1:0]   cnt_q, zdc_q;
  logic            last_sample, in_ready_c;

  // Operand magnitudes, saturation decision and one restoring-division step
  always_comb begin
    diff   = {a_q[XLEN-1], a_q} - {e_q[XLEN-1], e_q};
    ed     = diff[EW-1] ? EW'(-diff) : diff;
    d      = e_q[XLEN-1] ? EW'(-{e_q[XLEN-1], e_q}) : {1'b0, e_q};
    d_zero = (d == '0);
    sat    = ((EW+IB)'(ed) >= {d, {IB{1'b0}}});
    num    = {ed, {FRAC{1'b0}}};
    rem_sh = {rem[RMW-2:0], low[RW-1]};
    ge     = (rem_sh >= RMW'(d));
    rem_nx = ge ? (rem_sh - RMW'(d)) : rem_sh;
    quo_nx = {quo[RW-2:0], ge};
    sum_nx = sum_q + SW'(red_q);
    last_sample = (cnt_q == CW'((2 ** LOG2_N) - 1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.in_valid) state_next = CHECK;
      CHECK: state_next = (d_zero || sat) ? ACC : DIV;
      DIV:   if (iter == IW'(RW - 1)) state_next = ACC;
      ACC:   state_next = last_sample ? DONE : IDLE;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (bus.clear) state_next = IDLE;
  end

  // Output decode: ready only in IDLE and never while reset is held
  always_comb begin
    in_ready_c = 1'b0;
    if (state == IDLE && !reset) in_ready_c = 1'b1;
  end

  // Datapath: capture, divider, RED result and window accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0; e_q <= '0; rem <= '0; low <= '0; quo <= '0; iter <= '0;
      red_q <= '0; red_valid_q <= 1'b0; mred_q <= '0; stats_q <= 1'b0;
      sum_q <= '0; cnt_q <= '0; zdc_q <= '0;
    end else begin
      red_valid_q <= 1'b0;
      if (bus.clear) begin
        sum_q <= '0; cnt_q <= '0; zdc_q <= '0; mred_q <= '0; stats_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.in_valid) begin
            a_q <= bus.approx;
            e_q <= bus.exact;
          end
          CHECK: begin
            if (d_zero) begin
              red_q       <= (ed == '0) ? '0 : '1;
              red_valid_q <= 1'b1;
              zdc_q       <= zdc_q + CW'(1);
            end else if (sat) begin
              red_q       <= '1;
              red_valid_q <= 1'b1;
            end else begin
              rem  <= RMW'(num[NW-1:RW]);
              low  <= num[RW-1:0];
              quo  <= '0;
              iter <= '0;
            end
          end
          DIV: begin
            rem  <= rem_nx;
            low  <= {low[RW-2:0], 1'b0};
            quo  <= quo_nx;
            iter <= iter + IW'(1);
            if (iter == IW'(RW - 1)) begin
              red_q       <= quo_nx;
              red_valid_q <= 1'b1;
            end
          end
          ACC: begin
            sum_q <= sum_nx;
            cnt_q <= cnt_q + CW'(1);
            if (last_sample) begin
              stats_q <= 1'b1;
              mred_q  <= sum_nx[SW-1:LOG2_N];
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RED_MAX_TRACK_EN
  logic [RW-1:0] max_q;

  // Peak RED over the current window
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                max_q <= '0;
    else if (bus.clear)                       max_q <= '0;
    else if (state == ACC && red_q > max_q)   max_q <= red_q;
  end

  assign bus.red_max = max_q;
`else
  assign bus.red_max = '0;
`endif

  assign bus.in_ready     = in_ready_c;
  assign bus.red_out      = red_q;
  assign bus.red_valid    = red_valid_q;
  assign bus.mred         = mred_q;
  assign bus.stats_valid  = stats_q;
  assign bus.zero_div_cnt = zdc_q;
endmodule
